// File: rtl/vga_vid_fetch.sv
// vga_vid_fetch: Wishbone read master that streams the active frame
// buffer into the pixel line FIFO in bursts, with frame wrap and bank switch.
module vga_vid_fetch (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        ven,
    input  logic        vbsw,
    input  logic [1:0]  vbl,
    input  logic [1:0]  cd,
    input  logic [15:0] Thgate,
    input  logic [15:0] Tvgate,
    input  logic [29:0] VBARa,
    input  logic [29:0] VBARb,
    input  logic        fifo_nfull,
    output logic [29:0] ADR_O,
    output logic        CYC_O,
    output logic        STB_O,
    input  logic        ACK_I,
    input  logic        ERR_I,
    input  logic [31:0] DAT_I,
    output logic        fifo_wreq,
    output logic [31:0] fifo_d,
    output logic        avmp,
    output logic        bsint_out,
    output logic        sint_out
);

    typedef enum logic [1:0] {IDLE, BURST, HALT} state_t;

    state_t      state;
    logic        cyc;
    logic        sof;
    logic [29:0] base;
    logic [29:0] offset;
    logic [16:0] wcnt;
    logic [15:0] lcnt;
    logic [16:0] lw_r;
    logic [15:0] tv_r;
    logic [3:0]  rem;

    logic [16:0] lw_use;
    logic [16:0] vlen;
    logic [16:0] left;
    logic [3:0]  blen;

    function automatic logic [16:0] line_words(input logic [1:0] c,
                                               input logic [15:0] th);
        logic [18:0] px;
        logic [18:0] by;
        px = {3'd0, th} + 19'd1;
        by = px + px * {17'd0, c};
        return 17'(by >> 2);
    endfunction

    // geometry comes straight from the registers when a new frame begins
    always_comb begin
        lw_use = sof ? line_words(cd, Thgate) : lw_r;
        vlen   = 17'd1 << vbl;
        left   = lw_use - wcnt;
        blen   = (left < vlen) ? left[3:0] : vlen[3:0];
    end

    assign CYC_O     = cyc;
    assign STB_O     = cyc;
    assign ADR_O     = base + offset;
    assign fifo_wreq = cyc & ACK_I & ~ERR_I;
    assign fifo_d    = DAT_I;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state     <= IDLE;
            cyc       <= 1'b0;
            sof       <= 1'b1;
            base      <= '0;
            offset    <= '0;
            wcnt      <= '0;
            lcnt      <= '0;
            lw_r      <= '0;
            tv_r      <= '0;
            rem       <= '0;
            avmp      <= 1'b0;
            bsint_out <= 1'b0;
            sint_out  <= 1'b0;
        end else begin
            bsint_out <= 1'b0;
            sint_out  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!ven) begin
                        offset <= '0;
                        wcnt   <= '0;
                        lcnt   <= '0;
                        sof    <= 1'b1;
                    end else if (!fifo_nfull) begin
                        state <= BURST;
                        cyc   <= 1'b1;
                        rem   <= blen;
                        sof   <= 1'b0;
                        if (sof) begin
                            lw_r <= lw_use;
                            tv_r <= Tvgate;
                            base <= avmp ? VBARb : VBARa;
                        end
                    end
                end
                BURST: begin
                    if (ERR_I) begin
                        state    <= HALT;
                        cyc      <= 1'b0;
                        sint_out <= 1'b1;
                        offset   <= '0;
                        wcnt     <= '0;
                        lcnt     <= '0;
                        sof      <= 1'b1;
                    end else if (ACK_I) begin
                        offset <= offset + 30'd1;
                        rem    <= rem - 4'd1;
                        if (wcnt == lw_r - 17'd1) begin
                            wcnt <= '0;
                            if (lcnt == tv_r) begin
                                lcnt   <= '0;
                                offset <= '0;
                                sof    <= 1'b1;
                                if (vbsw) begin
                                    avmp      <= ~avmp;
                                    bsint_out <= 1'b1;
                                end
                            end else begin
                                lcnt <= lcnt + 16'd1;
                            end
                        end else begin
                            wcnt <= wcnt + 17'd1;
                        end
                        if (rem == 4'd1) begin
                            state <= IDLE;
                            cyc   <= 1'b0;
                        end
                    end
                end
                HALT: begin
                    if (!ven)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vga_vid_fetch.md
# vga_vid_fetch

Video-memory fetch sequencer for the VGA/LCD controller. Acts as a Wishbone master that streams the active frame buffer (VBARa or VBARb) into the pixel line FIFO in bursts, using the geometry, colour depth and burst length programmed through the Wishbone slave register block. Handles end-of-frame wrap and video bank switching. Raises the bank-switch and system-error interrupt requests consumed by the status register.

## Interface
- No parameters; all widths fixed.
- CLK_I  in  1  system clock; all logic rising-edge.
- RST_I  in  1  asynchronous, active-high reset.
- ven  in  1  video enable (ctrl[0]).
- vbsw  in  1  video bank-switch enable (ctrl[4]).
- vbl  in  2  burst length: 00=1, 01=2, 10=4, 11=8 words.
- cd  in  2  colour depth: 00=8, 01=16, 10=24, 11=32 bpp.
- Thgate  in  16  visible pixels per line minus 1.
- Tvgate  in  16  visible lines per frame minus 1.
- VBARa, VBARb  in  30  frame base word addresses [31:2].
- fifo_nfull  in  1  line FIFO has fewer than 8 free entries.
- ADR_O  out  30  word address [31:2].
- CYC_O, STB_O  out  1  Wishbone cycle/strobe; read-only master, no WE_O/SEL_O (always read, all bytes).
- ACK_I, ERR_I  in  1  Wishbone acknowledge / error.
- DAT_I  in  32  read data.
- fifo_wreq  out  1  FIFO write strobe, = CYC_O & STB_O & ACK_I.
- fifo_d  out  32  FIFO write data, = DAT_I.
- avmp  out  1  active video memory page (0=A, 1=B).
- bsint_out  out  1  one-cycle bank-switch interrupt request.
- sint_out  out  1  one-cycle system-error interrupt request.

## Operation
- Line words Lw = ((Thgate+1) * bytes_per_pixel) >> 2, bytes_per_pixel = 1/2/3/4 from cd. Software guarantees (Thgate+1) divisible by 4 for 8/24 bpp and by 2 for 16 bpp; no rounding logic.
- Counters: wcnt (word within line, 0..Lw-1), lcnt (line, 0..Tvgate), offset (word offset from frame base, 30 bit, wraps modulo 2^30).
- Frame start (offset=0, first burst): latch cd, Thgate, Tvgate, and base = avmp ? VBARb : VBARa. Register changes mid-frame take effect at the next frame.
- Burst length blen = min(vbl length, Lw - wcnt); latched at burst start from current vbl. Bursts never cross a line end.
- States:
  - IDLE: CYC_O=STB_O=0. Go to BURST when ven & !fifo_nfull.
  - BURST: CYC_O=STB_O=1, ADR_O = base + offset. On each ACK_I: offset++, wcnt++ (at Lw: wcnt=0, lcnt++), remaining blen--. On last ACK: return to IDLE.
  - HALT: CYC_O=STB_O=0. Leave to IDLE only when ven=0.
- End of frame: the ACK of word (Lw-1) on line Tvgate sets offset=wcnt=lcnt=0. If vbsw=1: avmp toggles and bsint_out pulses the same cycle as the registered update. If vbsw=0: avmp unchanged, no pulse; the next frame restarts at the same base.
- ERR_I during BURST: no FIFO write for that cycle; sint_out pulses; CYC_O/STB_O drop; go to HALT; counters reset to frame start; avmp retained.
- ven falling during BURST: current burst completes normally. In IDLE with ven=0: counters reset to frame start; avmp retained.
- ACK_I and ERR_I together: ERR_I wins.

## Timing
- Reset values: CYC_O=0, STB_O=0, ADR_O=0, avmp=0, bsint_out=0, sint_out=0. State IDLE, all counters 0. fifo_wreq=0 because CYC_O=0.
- IDLE to first strobe: one cycle (condition seen at edge n, CYC_O high after edge n).
- Zero-wait-state slave: one word per cycle. ADR_O advances on the edge following each ACK_I.
- CYC_O deasserts on the edge after the last ACK_I and stays low for at least one cycle between bursts.
- fifo_wreq/fifo_d are combinational, valid in the ACK_I cycle.
- bsint_out/sint_out are registered and high exactly one cycle, on the edge after the triggering ACK_I/ERR_I.
- Reset asserted mid-burst: CYC_O/STB_O low immediately (asynchronous); no further fifo_wreq.

## Test plan
- 8 bpp, Thgate=15 (Lw=4), Tvgate=1, vbl=01, VBARa=0x40, vbsw=0, zero-wait ACK -> 4 bursts of 2 at ADR_O 0x40/41, 42/43, 44/45, 46/47; then 0x40 again; avmp stays 0; 8 fifo_wreq per frame.
- Same setup with vbsw=1, VBARb=0x80 -> bsint_out 1-cycle pulse after ACK at 0x47; avmp=1; next burst starts at 0x80; after the next frame, avmp=0 and fetch returns to 0x40.
- 32 bpp, Thgate=4 (Lw=5), vbl=11 -> bursts of exactly 5 words per line, never 8.
- fifo_nfull=1 with ven=1 -> CYC_O stays 0 indefinitely. Releasing it -> CYC_O=1 next cycle.
- ERR_I on the 2nd word of a 4-word burst -> 1 fifo_wreq only, sint_out pulses, CYC_O=0, HALT persists while ven=1. After ven 0 then 1, fetch restarts at frame base.
- RST_I pulsed mid-burst -> CYC_O/STB_O/avmp=0 immediately. After release with ven=1, first burst at VBARa.
